// File: rtl/id_ex_stage_reg_pkg.sv
// rtl/id_ex_stage_reg_pkg.sv - shared pipeline widths, encodings and ID/EX control bundle
//
// Contents:
//   DATA_W, REG_AW, ALUOP_W  default datapath widths
//   ALU_*                    ALU operation encodings
//   FWD_*                    forwarding-mux select constants
//   id_ex_ctrl_t             control bundle carried through ID/EX
package id_ex_stage_reg_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'h1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'h2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'h3;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'h4;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'h5;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'h6;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'h7;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// rtl/id_ex_stage_reg_load_use_detect.sv - combinational load-use hazard detector
//
// Ports:
//   id_valid                  ID holds a real instruction
//   ex_valid, ex_mem_read,
//   ex_reg_write, ex_reg_rd   instruction currently in ID/EX
//   id_reg_rs, id_reg_rt      source indices of the ID instruction
//   hz                        ID instruction needs a value still being loaded
module load_use_detect
    import id_ex_stage_reg_pkg::*;
#(
    parameter int RAW = REG_AW
) (
    input  logic           id_valid,
    input  logic           ex_valid,
    input  logic           ex_mem_read,
    input  logic           ex_reg_write,
    input  logic [RAW-1:0] ex_reg_rd,
    input  logic [RAW-1:0] id_reg_rs,
    input  logic [RAW-1:0] id_reg_rt,
    output logic           hz
);

    // rt is compared even for I-type: a false stall is cheap, a missed one is not.
    assign hz = id_valid & ex_valid & ex_mem_read & ex_reg_write
              & (ex_reg_rd != '0)
              & ((ex_reg_rd == id_reg_rs) | (ex_reg_rd == id_reg_rt));

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use stall, hold and flush
//
// Optional feature macro: ID_EX_PERF_CNT_EN (adds bubble_cnt / flush_cnt).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ext_stall                 hold ID/EX contents (downstream stall)
//   flush                     kill the next ID/EX entry
//   id_*                      decoded fields from ID
//   id_ex_*                   registered fields to EX / forwarding_unit
//   pc_write, if_id_write     0 freezes the front end
//   load_use_stall            hazard bubble inserted this cycle
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DW  = DATA_W,
    parameter int RAW = REG_AW,
    parameter int AOW = ALUOP_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ext_stall,
    input  logic           flush,
    input  logic           id_valid,
    input  logic [RAW-1:0] id_reg_rs,
    input  logic [RAW-1:0] id_reg_rt,
    input  logic [RAW-1:0] id_reg_rd,
    input  logic           id_reg_write,
    input  logic           id_mem_read,
    input  logic           id_mem_write,
    input  logic           id_mem_to_reg,
    input  logic           id_alu_src,
    input  logic [AOW-1:0] id_alu_op,
    input  logic [DW-1:0]  id_rs_data,
    input  logic [DW-1:0]  id_rt_data,
    input  logic [DW-1:0]  id_imm,
    input  logic [DW-1:0]  id_pc,
    output logic           id_ex_valid,
    output logic [RAW-1:0] id_ex_reg_rs,
    output logic [RAW-1:0] id_ex_reg_rt,
    output logic [RAW-1:0] id_ex_reg_rd,
    output logic           id_ex_reg_write,
    output logic           id_ex_mem_read,
    output logic           id_ex_mem_write,
    output logic           id_ex_mem_to_reg,
    output logic           id_ex_alu_src,
    output logic [AOW-1:0] id_ex_alu_op,
    output logic [DW-1:0]  id_ex_rs_data,
    output logic [DW-1:0]  id_ex_rt_data,
    output logic [DW-1:0]  id_ex_imm,
    output logic [DW-1:0]  id_ex_pc,
    output logic           pc_write,
    output logic           if_id_write,
    output logic           load_use_stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]    bubble_cnt,
    output logic [31:0]    flush_cnt
`endif
);

    logic hz;
    logic fl;
    logic flush_pending;

    load_use_detect #(.RAW(RAW)) u_load_use_detect (
        .id_valid     (id_valid),
        .ex_valid     (id_ex_valid),
        .ex_mem_read  (id_ex_mem_read),
        .ex_reg_write (id_ex_reg_write),
        .ex_reg_rd    (id_ex_reg_rd),
        .id_reg_rs    (id_reg_rs),
        .id_reg_rt    (id_reg_rt),
        .hz           (hz)
    );

    // A flush seen during a stall is remembered and applied once the stall lifts.
    assign fl             = (flush | flush_pending) & ~ext_stall;
    // Flush beats the hazard: the dependent instruction is being killed anyway.
    assign load_use_stall = hz & ~ext_stall & ~fl;
    assign pc_write       = ~(ext_stall | load_use_stall);
    assign if_id_write    = ~(ext_stall | load_use_stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pending    <= 1'b0;
            id_ex_valid      <= 1'b0;
            id_ex_reg_rs     <= '0;
            id_ex_reg_rt     <= '0;
            id_ex_reg_rd     <= '0;
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_alu_op     <= '0;
            id_ex_rs_data    <= '0;
            id_ex_rt_data    <= '0;
            id_ex_imm        <= '0;
            id_ex_pc         <= '0;
        end else if (ext_stall) begin
            if (flush) begin
                flush_pending <= 1'b1;
            end
        end else if (fl || load_use_stall) begin
            // Bubble: zeroed indices keep forwarding_unit from matching; data is left alone.
            flush_pending    <= 1'b0;
            id_ex_valid      <= 1'b0;
            id_ex_reg_rs     <= '0;
            id_ex_reg_rt     <= '0;
            id_ex_reg_rd     <= '0;
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
        end else begin
            flush_pending    <= 1'b0;
            id_ex_valid      <= id_valid;
            id_ex_reg_rs     <= id_reg_rs;
            id_ex_reg_rt     <= id_reg_rt;
            id_ex_reg_rd     <= id_reg_rd;
            // A non-instruction must never write state.
            id_ex_reg_write  <= id_reg_write & id_valid;
            id_ex_mem_read   <= id_mem_read & id_valid;
            id_ex_mem_write  <= id_mem_write & id_valid;
            id_ex_mem_to_reg <= id_mem_to_reg;
            id_ex_alu_src    <= id_alu_src;
            id_ex_alu_op     <= id_alu_op;
            id_ex_rs_data    <= id_rs_data;
            id_ex_rt_data    <= id_rt_data;
            id_ex_imm        <= id_imm;
            id_ex_pc         <= id_pc;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (load_use_stall && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (fl && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage integer pipeline, with integrated load-use hazard detection, bubble insertion, hold and flush.
- Captures decoded fields from ID and presents id_ex_reg_rs/rt/rd, id_ex_reg_write and operands to EX and to forwarding_unit.
- Drives pc_write / if_id_write to freeze the front end on a load-use hazard or an external stall.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register index width
- ALUOP_W, 4, ALU op code width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ext_stall  in  1  downstream (memory) stall; hold ID/EX contents
- flush  in  1  branch/jump resolved taken in EX; kill next ID/EX entry
- id_valid  in  1  ID holds a real instruction
- id_reg_rs, id_reg_rt, id_reg_rd  in  REG_AW each  decoded register indices
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  in  1 each  control bits
- id_alu_op  in  ALUOP_W  ALU operation
- id_rs_data, id_rt_data, id_imm, id_pc  in  DATA_W each  operands/immediate/PC
- id_ex_valid  out  1  registered valid
- id_ex_reg_rs, id_ex_reg_rt, id_ex_reg_rd  out  REG_AW each  registered indices (to forwarding_unit)
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src  out  1 each
- id_ex_alu_op  out  ALUOP_W
- id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc  out  DATA_W each
- pc_write  out  1  comb; 0 freezes PC
- if_id_write  out  1  comb; 0 freezes IF/ID
- load_use_stall  out  1  comb; hazard bubble inserted this cycle

Behaviour:
- Reset: every id_ex_* output 0, flush_pending 0. Reset has priority over every other input.
- Hazard (comb): hz = id_valid & id_ex_valid & id_ex_mem_read & id_ex_reg_write & (id_ex_reg_rd != 0) & (id_ex_reg_rd == id_reg_rs | id_ex_reg_rd == id_reg_rt). Both rs and rt are always compared.
- Effective flush: fl = (flush | flush_pending) & ~ext_stall.
- load_use_stall = hz & ~ext_stall & ~fl.
- pc_write = if_id_write = ~(ext_stall | load_use_stall).
- Per-cycle update priority:
  - rst → reset.
  - ext_stall → hold all fields. Set flush_pending if flush=1.
  - fl → bubble, clear flush_pending.
  - load_use_stall → bubble.
  - otherwise → load all ID fields; id_ex_valid = id_valid.
- Bubble: id_ex_valid, reg_write, mem_read, mem_write, mem_to_reg = 0. id_ex_reg_rs/rt/rd = 0, so forwarding_unit never matches. Data fields keep their prior value.
- id_valid=0 while loading: fields are captured, but reg_write/mem_read/mem_write are forced to 0.
- Latency: 1 cycle ID → EX. A load-use hazard costs exactly one bubble, after which the held ID instruction loads.
- flush and hazard in the same cycle: flush wins; no load-use stall; the front end is not frozen.
- flush during ext_stall is never lost: it applies on the first non-stalled cycle.
- Mid-stall rst clears flush_pending.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- With macro: adds outputs bubble_cnt and flush_cnt, 32 bits each. They count load_use_stall cycles and applied flushes (fl) respectively, saturate at all-ones, and reset to 0.
- Without macro: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - REG_AW, DATA_W, ALUOP_W
  - ALU op encodings
  - Forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - An id_ex control-bundle typedef (valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op)
- One natural sub-module: load_use_detect, the combinational hz logic, reusable by other front-end stages.

Test Plan:
- Normal load: id_valid=1, rs=3, rt=4, rd=5, reg_write=1, rs_data=0x11 → next cycle id_ex_reg_rs=3, id_ex_reg_rd=5, id_ex_rs_data=0x11, id_ex_valid=1.
- Load-use: ID/EX holds lw with rd=7 and mem_read=1; ID has add with rs=7 → load_use_stall=1, pc_write=0, if_id_write=0; next cycle id_ex_valid=0, id_ex_reg_rd=0; the following cycle the add loads.
- Hazard on r0: ID/EX lw with rd=0, ID rs=0 → load_use_stall=0, pc_write=1.
- Flush: flush=1 while a hazard is present → load_use_stall=0, pc_write=1; next cycle id_ex_valid=0, id_ex_reg_write=0.
- Flush under stall: ext_stall=1 for 3 cycles with flush pulsed in cycle 1 → outputs held for 3 cycles; first non-stalled cycle inserts a bubble; flush_pending then 0.
- Reset mid-stall: ext_stall=1, flush_pending=1, rst=1 → all outputs 0; after release, ext_stall=0 with no flush → a normal load occurs, no spurious bubble.
